// File: rtl/nexys_starship_spawn_rng.sv
// nexys_starship_spawn_rng
//   Randomness and timebase stage feeding the four monster-lane FSMs.
//   A clock divider produces the timer_clk square wave; a 16-bit Galois LFSR
//   supplies one nibble per lane, and each lane raises a spawn-enable level
//   for one timer_clk period when its nibble is below SPAWN_THRESH. A lane
//   that fires is then held low for COOLDOWN ticks. Spawns only happen in RUN.
//
//   Optional feature: define STARSHIP_RNG_SEED_MIX_EN to XOR the divider
//   count into the LFSR reload on IDLE->RUN, so press timing varies each game.
//   Undefined, every game reloads LFSR_SEED and replays the same sequence.
//
// Ports
//   Clk           in   system clock, posedge
//   Reset         in   asynchronous reset, active-high
//   play_flag     in   game start/continue request (level)
//   gameover_ctrl in   any-lane game over (level)
//   timer_clk     out  divided square wave, 50 % duty, registered
//   lane_random   out  [3:0] spawn levels {right,left,btm,top}
//   rng_running   out  high while in RUN
//   lfsr_q        out  [15:0] current LFSR state
module nexys_starship_spawn_rng #(
  parameter int unsigned CLK_DIV      = 50_000_000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned SPAWN_THRESH = 4,
  parameter logic [3:0]  COOLDOWN     = 4'd2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic        gameover_ctrl,
  output logic        timer_clk,
  output logic [3:0]  lane_random,
  output logic        rng_running,
  output logic [15:0] lfsr_q
);

  // Counter is at least 16 bits wide so the seed mix always has 16 bits to use.
  localparam int          DIV_W    = ($clog2(CLK_DIV) > 16) ? $clog2(CLK_DIV) : 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Nibbles top out at 15, so any threshold above that behaves as 15.
  localparam logic [4:0]  THR      = (SPAWN_THRESH > 15) ? 5'd15 : 5'(SPAWN_THRESH);
  localparam logic [15:0] SEED_NZ  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_HALT = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             timer_clk_q, timer_clk_d;
  logic [15:0]      lfsr_r_q, lfsr_r_d;
  logic [3:0]       lane_q, lane_d;
  logic [3:0][3:0]  cool_q, cool_d;
  logic             running_q, running_d;

  logic             wrap, tick, run_hold, load;
  logic [15:0]      lfsr_shift, lfsr_load;

  // ---------------- divider ----------------
  assign wrap        = (div_cnt_q == DIV_LAST);
  assign tick        = wrap & ~timer_clk_q;   // cycle whose edge drives timer_clk 0->1
  assign div_cnt_d   = wrap ? '0 : div_cnt_q + DIV_W'(1);
  assign timer_clk_d = wrap ? ~timer_clk_q : timer_clk_q;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = play_flag ? S_RUN : S_IDLE;
      S_RUN:   state_d = gameover_ctrl ? S_HALT : S_RUN;
      // No auto-restart: player must release play_flag before a new game.
      S_HALT:  state_d = play_flag ? S_HALT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load      = (state_q == S_IDLE) & play_flag;
  assign run_hold  = (state_q == S_RUN) & ~gameover_ctrl;
  assign running_d = (state_d == S_RUN);

  // ---------------- LFSR ----------------
  assign lfsr_shift = {1'b0, lfsr_r_q[15:1]} ^ (lfsr_r_q[0] ? LFSR_MASK : 16'h0000);

`ifdef STARSHIP_RNG_SEED_MIX_EN
  logic [15:0] seed_mix;
  assign seed_mix  = LFSR_SEED ^ div_cnt_q[15:0];
  assign lfsr_load = (seed_mix == 16'h0000) ? 16'h0001 : seed_mix;
`else
  assign lfsr_load = SEED_NZ;
`endif

  assign lfsr_r_d = load ? lfsr_load : lfsr_shift;

  // ---------------- lane spawn ----------------
  // Outside RUN (including the RUN->HALT edge) everything is cleared, so a
  // tick that coincides with game over produces no spawn.
  always_comb begin
    lane_d = lane_q;
    cool_d = cool_q;
    for (int i = 0; i < 4; i++) begin
      if (!run_hold) begin
        lane_d[i] = 1'b0;
        cool_d[i] = 4'd0;
      end else if (tick) begin
        if (cool_q[i] != 4'd0) begin
          lane_d[i] = 1'b0;
          cool_d[i] = cool_q[i] - 4'd1;
        end else if ({1'b0, lfsr_r_q[4*i +: 4]} < THR) begin
          lane_d[i] = 1'b1;
          cool_d[i] = COOLDOWN;
        end else begin
          lane_d[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      timer_clk_q <= 1'b0;
      lfsr_r_q    <= SEED_NZ;
      lane_q      <= '0;
      cool_q      <= '0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      timer_clk_q <= timer_clk_d;
      lfsr_r_q    <= lfsr_r_d;
      lane_q      <= lane_d;
      cool_q      <= cool_d;
      running_q   <= running_d;
    end
  end

  assign timer_clk   = timer_clk_q;
  assign lane_random = lane_q;
  assign rng_running = running_q;
  assign lfsr_q      = lfsr_r_q;

endmodule

// File: tb/tb_nexys_starship_spawn_rng.sv
module tb_nexys_starship_spawn_rng;

  localparam int          CLK_DIV = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

`ifdef STARSHIP_RNG_SEED_MIX_EN
  localparam int          D1   = 1;
  localparam int          D2   = 3;
  localparam logic [15:0] LD1  = 16'hACE0;
  localparam logic [15:0] LD2  = 16'hACE2;
  localparam bit          SAME = 1'b0;
`else
  localparam int          D1   = 1;
  localparam int          D2   = 1;
  localparam logic [15:0] LD1  = 16'hACE1;
  localparam logic [15:0] LD2  = 16'hACE1;
  localparam bit          SAME = 1'b1;
`endif

  logic Clk = 1'b0, Reset = 1'b1, play_flag = 1'b0, gameover_ctrl = 1'b0;
  logic        tclk_a, tclk_b, tclk_c;
  logic [3:0]  lane_a, lane_b, lane_c;
  logic        run_a, run_b, run_c;
  logic [15:0] lfsr_a, lfsr_b, lfsr_c;

  always #5 Clk = ~Clk;

  // a: nominal threshold, b: over-range threshold (clamps to 15), c: never fires
  nexys_starship_spawn_rng #(.CLK_DIV(CLK_DIV), .LFSR_SEED(SEED), .SPAWN_THRESH(4), .COOLDOWN(4'd2)) u_a (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .timer_clk(tclk_a), .lane_random(lane_a), .rng_running(run_a), .lfsr_q(lfsr_a));
  nexys_starship_spawn_rng #(.CLK_DIV(CLK_DIV), .LFSR_SEED(SEED), .SPAWN_THRESH(20), .COOLDOWN(4'd2)) u_b (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .timer_clk(tclk_b), .lane_random(lane_b), .rng_running(run_b), .lfsr_q(lfsr_b));
  nexys_starship_spawn_rng #(.CLK_DIV(CLK_DIV), .LFSR_SEED(SEED), .SPAWN_THRESH(0), .COOLDOWN(4'd2)) u_c (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .timer_clk(tclk_c), .lane_random(lane_c), .rng_running(run_c), .lfsr_q(lfsr_c));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model of the spec (0 idle, 1 run, 2 halt)
  int          m_state, m_div, cyc_n;
  logic        m_tclk;
  logic [15:0] m_lfsr;
  logic [3:0]  m_lane [3];
  logic [3:0]  m_cool [3][4];
  int          thr [3] = '{4, 15, 0};

  bit          rec;
  logic [3:0]  tr_a[$], tr_b[$], tr_c[$];

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] seed_load(input int d);
    logic [15:0] s;
`ifdef STARSHIP_RNG_SEED_MIX_EN
    s = SEED ^ 16'(d);
    if (s == 16'h0000) s = 16'h0001;
`else
    s = SEED;
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_div = 0; m_tclk = 1'b0; m_lfsr = SEED; cyc_n = 0;
    for (int k = 0; k < 3; k++) begin
      m_lane[k] = 4'd0;
      for (int i = 0; i < 4; i++) m_cool[k][i] = 4'd0;
    end
  endtask

  // one Clk: advance the model on current inputs, then compare after the edge
  task automatic cyc();
    bit tick;
    tick = (m_div == CLK_DIV - 1) && !m_tclk;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        if (m_state == 1 && !gameover_ctrl) begin
          if (tick) begin
            if (m_cool[k][i] != 0) begin
              m_lane[k][i] = 1'b0; m_cool[k][i] = m_cool[k][i] - 4'd1;
            end else if (int'(m_lfsr[4*i +: 4]) < thr[k]) begin
              m_lane[k][i] = 1'b1; m_cool[k][i] = 4'd2;
            end else m_lane[k][i] = 1'b0;
          end
        end else begin
          m_lane[k][i] = 1'b0; m_cool[k][i] = 4'd0;
        end
      end
    m_lfsr = (m_state == 0 && play_flag) ? seed_load(m_div) : lstep(m_lfsr);
    case (m_state)
      0: if (play_flag) m_state = 1;
      1: if (gameover_ctrl) m_state = 2;
      default: if (!play_flag) m_state = 0;
    endcase
    if (m_div == CLK_DIV - 1) begin m_div = 0; m_tclk = ~m_tclk; end
    else m_div++;
    @(posedge Clk); #1;
    cyc_n++;
    chk($sformatf("tclk@%0d", cyc_n), {tclk_c, tclk_b, tclk_a}, {3{m_tclk}});
    chk($sformatf("lfsr@%0d", cyc_n), lfsr_a, m_lfsr);
    chk($sformatf("lfsr_bc@%0d", cyc_n), {lfsr_b, lfsr_c}, {m_lfsr, m_lfsr});
    chk($sformatf("run@%0d", cyc_n), {run_c, run_b, run_a}, {3{m_state == 1}});
    chk($sformatf("lane_a@%0d", cyc_n), lane_a, m_lane[0]);
    chk($sformatf("lane_b@%0d", cyc_n), lane_b, m_lane[1]);
    chk($sformatf("lane_c@%0d", cyc_n), lane_c, m_lane[2]);
    if (tick && rec) begin
      tr_a.push_back(lane_a); tr_b.push_back(lane_b); tr_c.push_back(lane_c);
    end
  endtask

  // async reset: outputs must clear before any Clk edge
  task automatic do_reset();
    #3 Reset = 1'b1;
    #1;
    chk("rst_tclk", {tclk_c, tclk_b, tclk_a}, 3'b000);
    chk("rst_lane", {lane_c, lane_b, lane_a}, 12'h000);
    chk("rst_run", {run_c, run_b, run_a}, 3'b000);
    chk("rst_lfsr", lfsr_a, 16'hACE1);
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // wait for a given divider phase (timer_clk low), then press play
  task automatic start_game(input int d, input logic [15:0] ld);
    play_flag = 1'b0;
    for (int n = 0; n < 16 && !(m_div == d && !m_tclk); n++) cyc();
    play_flag = 1'b1;
    cyc();
    chk("load_lfsr", lfsr_a, ld);
    chk("load_run", run_a, 1'b1);
  endtask

  task automatic record_ticks();
    tr_a.delete(); tr_b.delete(); tr_c.delete();
    rec = 1'b1;
    for (int n = 0; n < 120 && tr_a.size() < 10; n++) cyc();
    rec = 1'b0;
    chk("trace_len", tr_a.size(), 10);
  endtask

  logic [3:0] g1_a[$];
  int         rises[$];
  logic       prev;
  int         fired, diff;

  initial begin
    rec = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    do_reset();

    // timebase: rising edges at Clk 4, 12, 20
    for (int n = 0; n < 64; n++) begin
      prev = tclk_a;
      cyc();
      if (!prev && tclk_a) rises.push_back(cyc_n);
    end
    chk("rise0", rises.size() > 0 ? rises[0] : -1, 4);
    chk("rise1", rises.size() > 1 ? rises[1] : -1, 12);
    chk("rise2", rises.size() > 2 ? rises[2] : -1, 20);
    chk("rise_n", rises.size(), 8);

    // game 1
    start_game(D1, LD1);
    record_ticks();
    g1_a = tr_a;
    fired = 0;
    for (int j = 0; j < 8; j++)
      if (tr_b[j][0]) begin
        fired++;
        chk($sformatf("cool1_%0d", j), tr_b[j+1][0], 1'b0);
        chk($sformatf("cool2_%0d", j), tr_b[j+2][0], 1'b0);
      end
    chk("hi_fired", fired > 0, 1'b1);
    chk("zero_never", tr_c.size() == 10 && (tr_c[0] | tr_c[3] | tr_c[9]) == 4'd0, 1'b1);

    // game over on a tick cycle, play still held
    for (int n = 0; n < 16 && !(m_div == CLK_DIV - 1 && !m_tclk); n++) cyc();
    gameover_ctrl = 1'b1;
    cyc();
    chk("go_lane", lane_b, 4'd0);
    chk("go_run", run_a, 1'b0);
    gameover_ctrl = 1'b0;
    for (int n = 0; n < 10; n++) cyc();
    chk("halt_hold", run_a, 1'b0);
    chk("halt_lane", lane_b, 4'd0);
    play_flag = 1'b0;
    cyc();

    // game 2
    start_game(D2, LD2);
    record_ticks();
    diff = 0;
    for (int j = 0; j < 10; j++) begin
      if (tr_a[j] != g1_a[j]) diff++;
      if (SAME) chk($sformatf("replay_%0d", j), tr_a[j], g1_a[j]);
    end
    chk("traces_match", diff == 0, SAME);

    // reset in the middle of a running game
    for (int n = 0; n < 5; n++) cyc();
    do_reset();
    play_flag = 1'b0;
    for (int n = 0; n < 10; n++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
